// File: rtl/jtcop_mcu_mbox_if.sv
// jtcop_mcu_mbox_if: main-CPU and MCU side signals of the security mailbox
interface jtcop_mcu_mbox_if;
    logic        main_wr;
    logic        main_rd;
    logic [15:0] main_din;
    logic [15:0] main_dout;
    logic        sec2;
    logic [1:0]  mcu_a;
    logic        mcu_wr;
    logic        mcu_rd;
    logic [7:0]  mcu_din;
    logic [7:0]  mcu_dout;
    logic        mcu_intn;
    logic [2:0]  status;
    modport master(
        output main_wr, main_rd, main_din, mcu_a, mcu_wr, mcu_rd, mcu_din,
        input  main_dout, sec2, mcu_dout, mcu_intn, status
    );
    modport slave(
        input  main_wr, main_rd, main_din, mcu_a, mcu_wr, mcu_rd, mcu_din,
        output main_dout, sec2, mcu_dout, mcu_intn, status
    );
endinterface

// File: rtl/jtcop_mcu_mbox.sv
// jtcop_mcu_mbox: MCU-side mailbox latching 68000 commands and returning MCU replies with a sec2 pulse
module jtcop_mcu_mbox #(
    parameter int SEC2_LEN = 16,
    parameter int GAP_LEN  = 2
) (
    input logic             rst,
    input logic             clk,
    jtcop_mcu_mbox_if.slave mb
);
    localparam logic [7:0] PLEN = 8'(SEC2_LEN - 1);
    localparam logic [7:0] GLEN = 8'(GAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t      st;
    logic [7:0]  cnt;
    logic [15:0] cmd, stage, dout;
    logic        wr_l, rd_l, cmd_pend, reply_pend, overrun, intn, sec2;
    logic        wr_edge, rd_fall, rd_hi, rd_st, commit;

    assign wr_edge = mb.main_wr & ~wr_l;
    assign rd_fall = ~mb.main_rd & rd_l;
    assign rd_hi   = mb.mcu_rd && mb.mcu_a == 2'd1;
    assign rd_st   = mb.mcu_rd && mb.mcu_a == 2'd2;
    assign commit  = mb.mcu_wr && mb.mcu_a == 2'd2;

    assign mb.main_dout = dout;
    assign mb.sec2      = sec2;
    assign mb.mcu_intn  = intn;
    assign mb.status    = {overrun, reply_pend, cmd_pend};

    always_comb
        mb.mcu_dout = mb.mcu_a == 2'd0 ? cmd[7:0] :
                      mb.mcu_a == 2'd1 ? cmd[15:8] :
                      mb.mcu_a == 2'd2 ? {5'd0, overrun, reply_pend, cmd_pend} : 8'hff;

    // A new command edge always beats a same-cycle MCU acknowledge
    always_ff @(posedge clk, posedge rst)
        if (rst) begin
            wr_l       <= 1'b0;
            rd_l       <= 1'b0;
            cmd        <= 16'd0;
            stage      <= 16'd0;
            dout       <= 16'd0;
            cmd_pend   <= 1'b0;
            reply_pend <= 1'b0;
            overrun    <= 1'b0;
            intn       <= 1'b1;
        end else begin
            wr_l       <= mb.main_wr;
            rd_l       <= mb.main_rd;
            cmd        <= wr_edge ? mb.main_din : cmd;
            cmd_pend   <= wr_edge | (cmd_pend & ~rd_hi);
            intn       <= ~(wr_edge | (cmd_pend & ~rd_hi));
            overrun    <= (wr_edge & cmd_pend) | (overrun & ~rd_st);
            reply_pend <= commit | (reply_pend & ~rd_fall);
            dout       <= commit ? stage : dout;
            if (mb.mcu_wr && mb.mcu_a == 2'd0) stage[7:0]  <= mb.mcu_din;
            if (mb.mcu_wr && mb.mcu_a == 2'd1) stage[15:8] <= mb.mcu_din;
        end

    // A commit during a pulse inserts a low gap so the main CPU sees a fresh edge
    always_ff @(posedge clk, posedge rst)
        if (rst) begin
            st   <= IDLE;
            cnt  <= 8'd0;
            sec2 <= 1'b0;
        end else begin
            case (st)
                IDLE:
                    if (commit) begin
                        st   <= PULSE;
                        cnt  <= PLEN;
                        sec2 <= 1'b1;
                    end
                PULSE:
                    if (commit) begin
                        st   <= GAP;
                        cnt  <= GLEN;
                        sec2 <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        st   <= IDLE;
                        sec2 <= 1'b0;
                    end else cnt <= cnt - 8'd1;
                GAP:
                    if (cnt == 8'd0) begin
                        st   <= PULSE;
                        cnt  <= PLEN;
                        sec2 <= 1'b1;
                    end else cnt <= cnt - 8'd1;
                default: begin
                    st   <= IDLE;
                    sec2 <= 1'b0;
                end
            endcase
        end
endmodule
